// File: rtl/p405s_icu_pkg.sv
// Shared types and constants for the ICU fetch-address controller and its address mux.
package p405s_icu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REQ     = 2'd1,
        FILL    = 2'd2,
        RESTART = 2'd3
    } fetch_state_t;

    localparam logic [0:31] FETCH_INC  = 32'd8;
    localparam int          FILL_BEATS = 4;
    localparam int          LINE_OFS_W = 5;
    localparam int          BEAT_CNT_W = $clog2(FILL_BEATS);

    function automatic logic [0:31] line_align(input logic [0:31] addr);
        return {addr[0:31-LINE_OFS_W], {LINE_OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/p405s_icu_fetch_addr_ctl_if.sv
// PLB-side line-fill handshake between the fetch-address controller and the bus unit.
interface p405s_icu_fetch_addr_ctl_if;

    logic        plbReq;
    logic [0:31] plbAddr;
    logic        plbAck;
    logic        fillBeatV;

    modport master (
        output plbReq,
        output plbAddr,
        input  plbAck,
        input  fillBeatV
    );

    modport slave (
        input  plbReq,
        input  plbAddr,
        output plbAck,
        output fillBeatV
    );

endinterface

// File: rtl/p405s_icu_fetch_addr_sel.sv
// Priority mux choosing the next fetch address (regD) and its load enable (regE1).
module p405s_icu_fetch_addr_sel
    import p405s_icu_pkg::*;
#(
    parameter logic [0:31] RESET_VEC = 32'hFFFF_FFFC
) (
    input  logic         reset,
    input  fetch_state_t state,
    input  logic         hold,
    input  logic         flush_v,
    input  logic [0:31]  flush_addr,
    input  logic         br_v,
    input  logic [0:31]  br_addr,
    input  logic         miss_v,
    input  logic         ack,
    input  logic [0:31]  reg_l2,
    input  logic         pend_v,
    input  logic [0:31]  pend_addr,
    input  logic [0:31]  miss_addr,
    output logic [0:31]  reg_d,
    output logic         reg_e1
);

    logic        redirect;
    logic [0:31] redirect_addr;

    assign redirect      = flush_v | br_v;
    assign redirect_addr = flush_v ? flush_addr : br_addr;

    always_comb begin
        reg_d  = reg_l2;
        reg_e1 = 1'b0;
        if (reset) begin
            reg_d  = RESET_VEC;
            reg_e1 = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        reg_d  = redirect_addr;
                        reg_e1 = 1'b1;
                    end else if (!miss_v && !hold) begin
                        reg_d  = reg_l2 + FETCH_INC;
                        reg_e1 = 1'b1;
                    end
                end
                // An ack in the same cycle wins; the redirect is deferred as pending.
                REQ: begin
                    if (redirect && !ack) begin
                        reg_d  = redirect_addr;
                        reg_e1 = 1'b1;
                    end
                end
                FILL: begin
                    reg_e1 = 1'b0;
                end
                RESTART: begin
                    reg_e1 = 1'b1;
                    if (redirect)    reg_d = redirect_addr;
                    else if (pend_v) reg_d = pend_addr;
                    else             reg_d = miss_addr;
                end
                default: begin
                    reg_e1 = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/p405s_icu_fetch_addr_ctl.sv
// ICU fetch-address controller: drives the fetch register's D/E1 and sequences
// a line fill (request, FILL_BEATS beats, restart) after a cache miss.
module p405s_icu_fetch_addr_ctl
    import p405s_icu_pkg::*;
#(
    parameter logic [0:31] RESET_VEC = 32'hFFFF_FFFC
) (
    input  logic                               CB,
    input  logic                               reset,
    input  logic [0:31]                        regL2,
    output logic [0:31]                        regD,
    output logic                               regE1,
    input  logic                               hold,
    input  logic                               flushV,
    input  logic [0:31]                        flushAddr,
    input  logic                               brV,
    input  logic [0:31]                        brAddr,
    input  logic                               missV,
    p405s_icu_fetch_addr_ctl_if.master         plb,
    output logic                               fillBusy
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  pend_v;
    logic                  pend_flush;
    logic [0:31]           pend_addr;
    logic [0:31]           miss_addr;
    logic                  redirect;
    logic                  last_beat;
    logic                  take_miss;

    assign redirect  = flushV | brV;
    assign take_miss = (state == RUN) && !redirect && missV;
    // The beat arriving while the counter sits at FILL_BEATS-1 is the last of the line.
    assign last_beat = plb.fillBeatV && (beat_cnt == BEAT_CNT_W'(FILL_BEATS - 1));

    always_ff @(posedge CB) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take_miss) state_next = REQ;
            REQ: begin
                if (plb.plbAck)    state_next = FILL;
                else if (redirect) state_next = RUN;
            end
            FILL:    if (last_beat) state_next = RESTART;
            RESTART: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            beat_cnt   <= '0;
            pend_v     <= 1'b0;
            pend_flush <= 1'b0;
            pend_addr  <= '0;
            miss_addr  <= '0;
        end else begin
            if (take_miss) miss_addr <= regL2;

            if (state == REQ && plb.plbAck)            beat_cnt <= '0;
            else if (state == FILL && plb.fillBeatV)   beat_cnt <= beat_cnt + 1'b1;

            // A held flush is never displaced by a later branch.
            if (state == RESTART) begin
                pend_v     <= 1'b0;
                pend_flush <= 1'b0;
            end else if ((state == REQ && plb.plbAck) || state == FILL) begin
                if (flushV) begin
                    pend_v     <= 1'b1;
                    pend_flush <= 1'b1;
                    pend_addr  <= flushAddr;
                end else if (brV && !(pend_v && pend_flush)) begin
                    pend_v     <= 1'b1;
                    pend_flush <= 1'b0;
                    pend_addr  <= brAddr;
                end
            end
        end
    end

    p405s_icu_fetch_addr_sel #(
        .RESET_VEC (RESET_VEC)
    ) u_sel (
        .reset      (reset),
        .state      (state),
        .hold       (hold),
        .flush_v    (flushV),
        .flush_addr (flushAddr),
        .br_v       (brV),
        .br_addr    (brAddr),
        .miss_v     (missV),
        .ack        (plb.plbAck),
        .reg_l2     (regL2),
        .pend_v     (pend_v),
        .pend_addr  (pend_addr),
        .miss_addr  (miss_addr),
        .reg_d      (regD),
        .reg_e1     (regE1)
    );

    assign plb.plbReq  = !reset && (state == REQ);
    assign plb.plbAddr = line_align(miss_addr);
    assign fillBusy    = !reset && (state != RUN);

endmodule

// File: tb/tb_p405s_icu_fetch_addr_ctl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// behavioural model of the fetch address and line-fill sequence.
module tb_p405s_icu_fetch_addr_ctl;
    import p405s_icu_pkg::*;

    localparam logic [31:0] RESET_VEC = 32'hFFFF_FFFC;

    logic        CB;
    logic        reset;
    logic [0:31] regL2;
    logic [0:31] regD;
    logic        regE1;
    logic        hold;
    logic        flushV;
    logic [0:31] flushAddr;
    logic        brV;
    logic [0:31] brAddr;
    logic        missV;
    logic        fillBusy;

    int check_count = 0;
    int fail_count  = 0;

    // Model: fetch pc plus a description of the outstanding fill.
    logic [31:0] m_pc;
    bit          m_pc_known = 0;
    bit          m_wait_ack = 0;
    int          m_beats_left = 0;
    bit          m_restart_due = 0;
    bit          m_has_redir = 0;
    bit          m_redir_flush = 0;
    logic [31:0] m_redir_addr = '0;
    logic [31:0] m_miss_pc = '0;

    p405s_icu_fetch_addr_ctl_if plb_bus ();

    p405s_icu_fetch_addr_ctl #(
        .RESET_VEC (RESET_VEC)
    ) dut (
        .CB        (CB),
        .reset     (reset),
        .regL2     (regL2),
        .regD      (regD),
        .regE1     (regE1),
        .hold      (hold),
        .flushV    (flushV),
        .flushAddr (flushAddr),
        .brV       (brV),
        .brAddr    (brAddr),
        .missV     (missV),
        .plb       (plb_bus.master),
        .fillBusy  (fillBusy)
    );

    initial begin
        CB = 1'b0;
        forever #5 CB = ~CB;
    end

    // Enable-only fetch register with no reset, fed by the controller.
    always_ff @(posedge CB) begin
        if (regE1) regL2 <= regD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic noteRedirect(input bit f, input logic [31:0] fa, input bit b, input logic [31:0] ba);
        if (f) begin
            m_has_redir = 1; m_redir_flush = 1; m_redir_addr = fa;
        end else if (b && !(m_has_redir && m_redir_flush)) begin
            m_has_redir = 1; m_redir_flush = 0; m_redir_addr = ba;
        end
    endtask

    // Called at posedge+1; drives one cycle, checks outputs, advances model past the edge.
    task automatic applyStimulus(input bit r, input bit h, input bit f, input logic [31:0] fa,
                                 input bit b, input logic [31:0] ba, input bit m, input bit a, input bit bt);
        logic [31:0] e_d;
        bit          e_e1, e_req, e_busy, redir;
        logic [31:0] redir_addr;
        reset = r; hold = h; flushV = f; flushAddr = fa; brV = b; brAddr = ba; missV = m;
        plb_bus.plbAck = a; plb_bus.fillBeatV = bt;
        #2;
        redir = f | b;
        redir_addr = f ? fa : ba;
        e_d = '0; e_e1 = 0; e_req = 0; e_busy = 0;
        if (r) begin
            e_e1 = 1; e_d = RESET_VEC;
        end else if (m_restart_due) begin
            e_busy = 1; e_e1 = 1;
            e_d = redir ? redir_addr : (m_has_redir ? m_redir_addr : m_miss_pc);
        end else if (m_wait_ack) begin
            e_busy = 1; e_req = 1;
            if (redir && !a) begin e_e1 = 1; e_d = redir_addr; end
        end else if (m_beats_left > 0) begin
            e_busy = 1;
        end else if (redir) begin
            e_e1 = 1; e_d = redir_addr;
        end else if (!m && !h) begin
            e_e1 = 1; e_d = m_pc + FETCH_INC;
        end
        checkOutput("regE1", 32'(regE1), 32'(e_e1));
        if (e_e1) checkOutput("regD", regD, e_d);
        checkOutput("plbReq", 32'(plb_bus.plbReq), 32'(e_req));
        checkOutput("fillBusy", 32'(fillBusy), 32'(e_busy));
        if (e_req) checkOutput("plbAddr", plb_bus.plbAddr, m_miss_pc & ~32'h1F);
        @(posedge CB);
        #1;
        if (r) begin
            m_wait_ack = 0; m_beats_left = 0; m_restart_due = 0; m_has_redir = 0;
        end else if (m_restart_due) begin
            m_restart_due = 0; m_has_redir = 0;
        end else if (m_wait_ack) begin
            if (a) begin
                m_wait_ack = 0; m_beats_left = FILL_BEATS;
                noteRedirect(f, fa, b, ba);
            end else if (redir) begin
                m_wait_ack = 0;
            end
        end else if (m_beats_left > 0) begin
            noteRedirect(f, fa, b, ba);
            if (bt) begin
                m_beats_left--;
                if (m_beats_left == 0) m_restart_due = 1;
            end
        end else if (!redir && m) begin
            m_miss_pc = m_pc; m_wait_ack = 1;
        end
        if (e_e1) begin m_pc = e_d; m_pc_known = 1; end
        if (m_pc_known) checkOutput("regL2", regL2, m_pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, '0, 0, 0, 0);
    endtask

    task automatic beat();
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 0, 1);
    endtask

    logic [31:0] seq_exp [4];
    bit          rr, rh, rf, rb, rm, ra, rbt;
    logic [31:0] rfa, rba;

    initial begin
        reset = 1'b1; hold = 0; flushV = 0; brV = 0; missV = 0;
        flushAddr = '0; brAddr = '0;
        plb_bus.plbAck = 0; plb_bus.fillBeatV = 0;
        @(posedge CB); #1;

        // Reset release and sequential fetch, including the wrap past zero.
        applyStimulus(1, 0, 0, '0, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0, 0, 0);
        checkOutput("reset_vec", regL2, RESET_VEC);
        checkOutput("reset_busy", 32'(fillBusy), 32'(1'b0));
        seq_exp[0] = 32'h0000_0004; seq_exp[1] = 32'h0000_000C; seq_exp[2] = 32'h0000_0014;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checkOutput("seq_pc", regL2, seq_exp[i]);
        end

        // Flush beats branch in the same cycle.
        applyStimulus(0, 0, 1, 32'h0000_0700, 1, 32'h0000_1000, 0, 0, 0);
        checkOutput("flush_prio", regL2, 32'h0000_0700);

        // Miss at 0x1234, ack after two cycles, four gapped beats, restart.
        applyStimulus(0, 0, 0, '0, 1, 32'h0000_1234, 0, 0, 0);
        applyStimulus(0, 0, 0, '0, 0, '0, 1, 0, 0);
        checkOutput("miss_req", 32'(plb_bus.plbReq), 32'(1'b1));
        checkOutput("miss_addr", plb_bus.plbAddr, 32'h0000_1220);
        idle(2);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1, 0);
        beat(); idle(1); beat(); idle(2); beat(); idle(1); beat();
        idle(1);
        checkOutput("restart_pc", regL2, 32'h0000_1234);
        checkOutput("restart_busy", 32'(fillBusy), 32'(1'b0));

        // Branch cancels an unacknowledged request.
        applyStimulus(0, 0, 0, '0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, 0, '0, 1, 32'h0000_2000, 0, 0, 0);
        checkOutput("cancel_req", 32'(plb_bus.plbReq), 32'(1'b0));
        checkOutput("cancel_pc", regL2, 32'h0000_2000);
        checkOutput("cancel_busy", 32'(fillBusy), 32'(1'b0));

        // Branch then flush during the fill; the flush target wins at restart.
        applyStimulus(0, 0, 0, '0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1, 0);
        applyStimulus(0, 0, 0, '0, 1, 32'h0000_3000, 0, 0, 1);
        idle(1);
        applyStimulus(0, 0, 1, 32'h0000_0700, 0, '0, 0, 0, 1);
        beat(); beat();
        idle(1);
        checkOutput("pend_flush_pc", regL2, 32'h0000_0700);

        // Reset during the second beat abandons the fill; stray beats are ignored.
        applyStimulus(0, 0, 0, '0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1, 0);
        beat();
        applyStimulus(1, 0, 0, '0, 0, '0, 0, 0, 1);
        checkOutput("midfill_req", 32'(plb_bus.plbReq), 32'(1'b0));
        checkOutput("midfill_busy", 32'(fillBusy), 32'(1'b0));
        checkOutput("midfill_pc", regL2, RESET_VEC);
        beat(); beat(); beat();
        checkOutput("stray_busy", 32'(fillBusy), 32'(1'b0));

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 255) == 0);
            rh  = ($urandom_range(0, 3) == 0);
            rf  = ($urandom_range(0, 19) == 0);
            rb  = ($urandom_range(0, 14) == 0);
            rm  = ($urandom_range(0, 5) == 0);
            ra  = ($urandom_range(0, 2) == 0);
            rbt = ($urandom_range(0, 1) == 0);
            rfa = $urandom;
            rba = $urandom;
            applyStimulus(rr, rh, rf, rfa, rb, rba, rm, ra, rbt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
